// File: rtl/bcd_countdown_timer.sv
// 4-digit BCD down-counter with a loadable preset, a run/pause/expire state
// machine and a one-cycle done pulse. Digit 3 holds the thousands and digit 0
// the units. The count advances only on enable_i ticks while in RUN.
module bcd_countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [3:0] load3_i,
    input  logic [3:0] load2_i,
    input  logic [3:0] load1_i,
    input  logic [3:0] load0_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       enable_i,
    output logic [3:0] bcd3_o,
    output logic [3:0] bcd2_o,
    output logic [3:0] bcd1_o,
    output logic [3:0] bcd0_o,
    output logic       running_o,
    output logic       done_o,
    output logic       zero_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] preset_q, preset_d;
    logic        done_q, done_d;
    logic        running_q, running_d;
    logic [15:0] load_clamped_s;

    // Limit a raw digit to the BCD range so the count can never hold A-F.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Decrement a 4-digit BCD value by one; a zero digit wraps to 9 and
    // borrows from the next digit up. Only used on non-zero counts.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [15:0] r;
        logic        borrow;
        r      = c;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (c[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = c[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = c[4*i +: 4];
            end
        end
        return r;
    endfunction

    assign load_clamped_s = {clamp_digit(load3_i), clamp_digit(load2_i),
                             clamp_digit(load1_i), clamp_digit(load0_i)};

    // Next-state logic: command priority is clear > load > pause > start > tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        done_d   = 1'b0;
        if (clear_i) begin
            count_d  = 16'h0000;
            preset_d = 16'h0000;
            state_d  = ST_IDLE;
        end else if (load_i) begin
            count_d  = load_clamped_s;
            preset_d = load_clamped_s;
            state_d  = ST_IDLE;
        end else if (pause_i) begin
            // Pause only has an effect while running; it still masks start/tick.
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end else begin
                state_d = state_q;
            end
        end else if (start_i && (state_q != ST_RUN)) begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q == 16'h0000) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    state_d = ST_RUN;
                end
                ST_EXPIRED: begin
                    count_d = preset_q;
                    if (preset_q == 16'h0000) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (enable_i && (state_q == ST_RUN)) begin
            if (count_q == 16'h0001) begin
                done_d = 1'b1;
                if (AUTO_RELOAD) begin
                    count_d = preset_q;
                    state_d = ST_RUN;
                end else begin
                    count_d = 16'h0000;
                    state_d = ST_EXPIRED;
                end
            end else if (count_q != 16'h0000) begin
                count_d = bcd_dec(count_q);
            end else begin
                count_d = count_q;
            end
        end else begin
            state_d = state_q;
        end
        running_d = (state_d == ST_RUN);
    end

    // State, count, preset and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 16'h0000;
            preset_q  <= 16'h0000;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            preset_q  <= preset_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign bcd3_o    = count_q[15:12];
    assign bcd2_o    = count_q[11:8];
    assign bcd1_o    = count_q[7:4];
    assign bcd0_o    = count_q[3:0];
    assign running_o = running_q;
    assign done_o    = done_q;
    assign zero_o    = (count_q == 16'h0000);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer. Two instances share all inputs:
// u_dut stops in EXPIRED, u_dut_ar auto-reloads. An integer reference model
// predicts each instance's outputs; expectations are queued when stimulus is
// driven and compared after the next rising edge.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, load, start, pause, enable;
    logic [15:0] dig;
    wire  [15:0] cnt0, cnt1;
    wire         run0, run1, done0, done1, zero0, zero1;

    int n_vec = 0;
    int n_err = 0;
    int ar_done_cnt = 0;

    typedef struct {
        int          which;
        logic [15:0] cnt;
        logic        run;
        logic        done;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    // model state per instance: 0 idle, 1 run, 2 paused, 3 expired
    int m_cnt[2];
    int m_pre[2];
    int m_st[2];
    bit m_done[2];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .load_i(load),
        .load3_i(dig[15:12]), .load2_i(dig[11:8]), .load1_i(dig[7:4]), .load0_i(dig[3:0]),
        .start_i(start), .pause_i(pause), .enable_i(enable),
        .bcd3_o(cnt0[15:12]), .bcd2_o(cnt0[11:8]), .bcd1_o(cnt0[7:4]), .bcd0_o(cnt0[3:0]),
        .running_o(run0), .done_o(done0), .zero_o(zero0)
    );

    bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) u_dut_ar (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .load_i(load),
        .load3_i(dig[15:12]), .load2_i(dig[11:8]), .load1_i(dig[7:4]), .load0_i(dig[3:0]),
        .start_i(start), .pause_i(pause), .enable_i(enable),
        .bcd3_o(cnt1[15:12]), .bcd2_o(cnt1[11:8]), .bcd1_o(cnt1[7:4]), .bcd0_o(cnt1[3:0]),
        .running_o(run1), .done_o(done1), .zero_o(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int digit_val(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_done[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit ar, input bit c, input bit l,
                              input logic [15:0] d, input bit s, input bit p, input bit e);
        m_done[k] = 1'b0;
        if (c) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_st[k] = 0;
        end else if (l) begin
            m_cnt[k] = digit_val(d[15:12]) * 1000 + digit_val(d[11:8]) * 100 +
                       digit_val(d[7:4]) * 10 + digit_val(d[3:0]);
            m_pre[k] = m_cnt[k];
            m_st[k]  = 0;
        end else if (p) begin
            if (m_st[k] == 1) m_st[k] = 2;
        end else if (s && m_st[k] != 1) begin
            if (m_st[k] == 0) begin
                if (m_cnt[k] == 0) begin m_st[k] = 3; m_done[k] = 1'b1; end
                else m_st[k] = 1;
            end else if (m_st[k] == 2) begin
                m_st[k] = 1;
            end else begin
                m_cnt[k] = m_pre[k];
                if (m_pre[k] == 0) m_done[k] = 1'b1;
                else m_st[k] = 1;
            end
        end else if (e && m_st[k] == 1) begin
            if (m_cnt[k] == 1) begin
                m_done[k] = 1'b1;
                if (ar) m_cnt[k] = m_pre[k];
                else begin m_cnt[k] = 0; m_st[k] = 3; end
            end else if (m_cnt[k] > 0) begin
                m_cnt[k] = m_cnt[k] - 1;
            end
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.which == 0) begin
                chk("d0_count", 32'(cnt0), 32'(e.cnt));
                chk("d0_running", 32'(run0), 32'(e.run));
                chk("d0_done", 32'(done0), 32'(e.done));
                chk("d0_zero", 32'(zero0), 32'(e.zero));
            end else begin
                chk("d1_count", 32'(cnt1), 32'(e.cnt));
                chk("d1_running", 32'(run1), 32'(e.run));
                chk("d1_done", 32'(done1), 32'(e.done));
                chk("d1_zero", 32'(zero1), 32'(e.zero));
                if (done1 === 1'b1) ar_done_cnt++;
            end
        end
    endtask

    task automatic cycle(input bit c, input bit l, input logic [15:0] d,
                         input bit s, input bit p, input bit e);
        exp_t x;
        @(negedge clk);
        clear = c; load = l; dig = d; start = s; pause = p; enable = e;
        for (int k = 0; k < 2; k++) begin
            model_step(k, (k == 1), c, l, d, s, p, e);
            x.which = k;
            x.cnt   = to_bcd(m_cnt[k]);
            x.run   = (m_st[k] == 1);
            x.done  = m_done[k];
            x.zero  = (m_cnt[k] == 0);
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic idle();            cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_load(input logic [15:0] d) ; cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_start();        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0); endtask
    task automatic tick();            cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0;
        pause = 1'b0; enable = 1'b0; dig = 16'h0;
        model_reset();
        #12;
        chk("reset_count", 32'(cnt0), 32'h0);
        chk("reset_running", 32'(run0), 32'h0);
        chk("reset_done", 32'(done0), 32'h0);
        chk("reset_zero", 32'(zero0), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // borrow through every digit
        do_load(16'h1000); do_start(); tick();
        chk("borrow_0999", 32'(cnt0), 32'h0999);
        chk("borrow_running", 32'(run0), 32'h1);

        // expire without reload, ticks ignored afterwards
        do_load(16'h0003); do_start();
        tick(); tick(); tick();
        chk("expire_count", 32'(cnt0), 32'h0000);
        chk("expire_done", 32'(done0), 32'h1);
        idle();
        chk("expire_done_one_cycle", 32'(done0), 32'h0);
        tick(); tick();
        chk("expired_hold", 32'(cnt0), 32'h0000);

        // auto reload with preset 0002
        do_load(16'h0002); do_start();
        ar_done_cnt = 0;
        for (int i = 0; i < 5; i++) begin tick(); idle(); end
        chk("ar_count", 32'(cnt1), 32'h0001);
        chk("ar_done_pulses", 32'(ar_done_cnt), 32'd2);
        chk("ar_running", 32'(run1), 32'h1);

        // pause beats a same-cycle tick; paused ignores ticks
        do_load(16'h0051); do_start(); tick();
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("pause_hold", 32'(cnt0), 32'h0050);
        for (int i = 0; i < 10; i++) tick();
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        chk("pause_over_start", 32'(run0), 32'h0);
        do_start(); tick();
        chk("resume_0049", 32'(cnt0), 32'h0049);

        // clamped load, and load in the middle of a run
        do_load(16'h0121); do_start(); tick();
        do_load(16'hAF39);
        chk("clamp_9939", 32'(cnt0), 32'h9939);
        chk("load_stops_run", 32'(run0), 32'h0);
        chk("load_no_done", 32'(done0), 32'h0);
        do_start(); tick();
        chk("clamp_preset_dec", 32'(cnt0), 32'h9938);

        // clear, then start at zero and restart from a zero preset
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        do_start();
        chk("start_at_zero_done", 32'(done0), 32'h1);
        idle(); do_start();
        chk("restart_zero_preset_done", 32'(done0), 32'h1);

        // expired restart from a non-zero preset
        do_load(16'h0002); do_start(); tick(); tick(); idle(); do_start();
        chk("restart_preset", 32'(cnt0), 32'h0002);
        chk("restart_running", 32'(run0), 32'h1);

        // random commands
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                  16'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end

        // asynchronous reset mid-count at 0457
        do_load(16'h0460); do_start(); tick(); tick(); tick();
        chk("pre_reset_0457", 32'(cnt0), 32'h0457);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_count", 32'(cnt0), 32'h0);
        chk("async_reset_running", 32'(run0), 32'h0);
        chk("async_reset_done", 32'(done0), 32'h0);
        chk("async_reset_count_ar", 32'(cnt1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- 4-digit BCD down-counter with a loadable preset, a run/pause/expire state machine and a one-cycle Done pulse.
- It is the count-down companion to the 4-digit BCD up-counter. It uses the same digit layout (BCD3 = thousands ... BCD0 = units) and the same ENABLE tick convention.
- It drives the same display path and feeds Done to the top-level control logic.

Parameters:
- AUTO_RELOAD, 0, when 1 an expiry reloads the preset and stays in RUN; when 0 an expiry stops in EXPIRED.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Clear  in  1  synchronous clear of the count and preset; returns to IDLE.
- Load  in  1  synchronous load of LOAD3..LOAD0 into both the preset and the count.
- LOAD3, LOAD2, LOAD1, LOAD0  in  4 each  preset digits.
- Start  in  1  begin or resume counting.
- Pause  in  1  suspend counting.
- ENABLE  in  1  count tick, one clock wide; decrements by 1 when in RUN.
- BCD3, BCD2, BCD1, BCD0  out  4 each  current count, registered.
- Running  out  1  high while in RUN.
- Done  out  1  one-cycle pulse on expiry.
- Zero  out  1  combinational; high when the count is 0000.

Behaviour:
- Reset (Resetn=0, async): BCD3..BCD0=0, preset=0000, state=IDLE, Done=0, Running=0.
- Command priority (synchronous): Clear > Load > Pause > Start > ENABLE tick.
- Clear: count=0000, preset=0000, state=IDLE, Done=0. Clear is accepted in any state.
- Load: count=preset=LOAD digits, state=IDLE, no Done. Any LOAD digit > 9 is clamped to 9 for both count and preset. Load is accepted in any state, including mid-run.
- States:
  - IDLE: Start moves to RUN. If the count is 0000 at Start, go to EXPIRED instead and pulse Done on the next cycle.
  - RUN: on ENABLE, decrement the count.
    - Units digit: 0 becomes 9 with a borrow into the tens digit. Tens and hundreds follow the same rule, and a borrow into the thousands digit decrements it.
    - If the pre-decrement count is 0001, the new count is 0000. Done=1 in the cycle after that edge, for exactly one cycle.
    - If AUTO_RELOAD=0, state becomes EXPIRED.
    - If AUTO_RELOAD=1, the same edge that would produce 0000 loads the preset instead. The count never shows 0000, Done still pulses, and the state stays RUN.
    - Pause moves to PAUSED. If Pause and ENABLE arrive in the same cycle, Pause wins and there is no decrement.
  - PAUSED: count is held and ENABLE is ignored; Start moves to RUN. If Start and Pause are both asserted, Pause wins and the block stays PAUSED.
  - EXPIRED: count holds 0000 and ENABLE is ignored. Start restarts from the preset: count=preset, state=RUN. If the preset is 0000, Done pulses again and the state stays EXPIRED.
- Running is registered and equals (state==RUN).
- Start while already in RUN has no effect.
- Latency:
  - Count changes are visible one clock after the ENABLE edge.
  - Done is asserted for the single cycle following the expiring edge.
- Done is never asserted by Clear, Load or Resetn.
- The count is always valid BCD, with every digit in the range 0–9, in all states.

Test Plan:
- Resetn low mid-count with count=0457 → outputs 0000, Running=0, Done=0 immediately, without waiting for a clock edge.
- Load 1000, Start, one ENABLE → count 0999 (borrow ripples through all digits).
- Load 0003, Start, three ENABLEs → counts 0002, 0001, 0000. Done pulses for exactly 1 cycle, state is EXPIRED, and further ENABLEs hold 0000.
- Load 0002 with AUTO_RELOAD=1, Start, 5 ENABLEs → counts 0001, 0002, 0001, 0002, 0001. Done pulses twice and Running stays 1.
- Count at 0050 in RUN, Pause and ENABLE in the same cycle → count stays 0050, PAUSED. Ten ENABLEs are ignored. Start then one ENABLE → 0049.
- Load digits A,F,3,9 → preset and count become 9939. Load while in RUN at 0120 → count=9939, state IDLE, Running=0, no Done.
